// File: rtl/code_packer_pkg.sv
// Shared definitions for the code packer and the encoder stage that feeds it.
package packer_pkg;
   localparam int OUT_W  = 32;
   localparam int CODE_W = 36;
   localparam int BUF_W  = 96;
   localparam int FILL_W = 7;
   localparam int LEN_W  = 6;

   typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/code_shift_align.sv
// Masks a code to its length and places it just below the current fill
// position of a left-aligned packing buffer.
module code_shift_align #(
   parameter int CODE_W = 36,
   parameter int BUF_W  = 96,
   parameter int FILL_W = 7,
   parameter int LEN_W  = 6
) (
   input  logic [CODE_W-1:0] code,
   input  logic [LEN_W-1:0]  len,
   input  logic [FILL_W-1:0] fill,
   output logic [BUF_W-1:0]  vec
);
   localparam logic [7:0] CODE_W8 = 8'(CODE_W);
   localparam logic [7:0] BUF_W8  = 8'(BUF_W);

   logic [7:0]        rsh;
   logic [7:0]        lsh;
   logic [CODE_W-1:0] masked;

   always_comb begin
      rsh    = CODE_W8 - 8'(len);
      masked = code & ({CODE_W{1'b1}} >> rsh);
      // fill + len never exceeds BUF_W, so the shift is always in range.
      lsh    = BUF_W8 - 8'(fill) - 8'(len);
      vec    = {{(BUF_W-CODE_W){1'b0}}, masked} << lsh;
   end
endmodule

// File: rtl/code_packer.sv
// Packs variable-length codes MSB-first into fixed-width output words, with
// flush/pad handling for the end of a stream.
module code_packer #(
   parameter int OUT_W  = 32,
   parameter int CODE_W = 36,
   parameter int BUF_W  = 96,
   parameter int FILL_W = 7
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [CODE_W-1:0] i_code,
   input  logic [5:0]        i_len,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [OUT_W-1:0]  o_word,
   output logic              o_last,
   output logic              o_flush_done,
   output logic              o_err,
   output logic [FILL_W-1:0] o_fill
);
   import packer_pkg::*;

   localparam logic [FILL_W-1:0] OUT_F   = FILL_W'(OUT_W);
   localparam logic [FILL_W-1:0] RDY_MAX = FILL_W'(BUF_W - CODE_W);

   state_t             state_q, state_d;
   logic [BUF_W-1:0]   buf_q, buf_sh, buf_d, app_vec;
   logic [FILL_W-1:0]  fill_q, fill_sh, fill_d;
   logic               err_q;
   logic               len_over;
   logic [LEN_W-1:0]   len_eff;
   logic               accept, emit;

   assign len_over = i_len > LEN_W'(CODE_W);
   assign len_eff  = len_over ? LEN_W'(CODE_W) : i_len;
   assign accept   = i_valid & o_ready;
   assign emit     = o_valid & i_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) state_q <= RUN;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (i_flush) state_d = FLUSH;
         FLUSH:   if (fill_d == '0) state_d = DONE;
         DONE:    state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Handshake outputs come only from registered state, never from i_ready.
   always_comb begin
      o_ready      = 1'b0;
      o_valid      = 1'b0;
      o_last       = 1'b0;
      o_flush_done = 1'b0;
      case (state_q)
         RUN: begin
            o_ready = (fill_q <= RDY_MAX);
            o_valid = (fill_q >= OUT_F);
         end
         FLUSH: begin
            o_valid = (fill_q != '0);
            o_last  = (fill_q != '0) && (fill_q <= OUT_F);
         end
         DONE:    o_flush_done = 1'b1;
         default: ;
      endcase
   end

   code_shift_align #(
      .CODE_W (CODE_W),
      .BUF_W  (BUF_W),
      .FILL_W (FILL_W),
      .LEN_W  (LEN_W)
   ) u_align (
      .code (i_code),
      .len  (len_eff),
      .fill (fill_sh),
      .vec  (app_vec)
   );

   // Emit shift happens first; a same-cycle append lands after the shifted data.
   always_comb begin
      buf_sh  = buf_q;
      fill_sh = fill_q;
      if (emit) begin
         buf_sh  = buf_q << OUT_W;
         fill_sh = (fill_q > OUT_F) ? (fill_q - OUT_F) : '0;
      end
      buf_d  = buf_sh;
      fill_d = fill_sh;
      if (accept) begin
         buf_d  = buf_sh | app_vec;
         fill_d = fill_sh + FILL_W'(len_eff);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         buf_q  <= '0;
         fill_q <= '0;
         err_q  <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         fill_q <= fill_d;
         if (accept && len_over) err_q <= 1'b1;
      end
   end

   assign o_word = buf_q[BUF_W-1 -: OUT_W];
   assign o_fill = fill_q;
   assign o_err  = err_q;
endmodule

// File: tb/tb_code_packer.sv
// Directed bench for code_packer: packing, flush/pad, backpressure, errors, reset.
module tb_code_packer;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready_in, flush;
   logic        ready, out_valid, last, flush_done, err;
   logic [35:0] code;
   logic [5:0]  len;
   logic [31:0] word;
   logic [6:0]  fill;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   code_packer dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_valid      (in_valid),
      .o_ready      (ready),
      .i_code       (code),
      .i_len        (len),
      .i_flush      (flush),
      .o_valid      (out_valid),
      .i_ready      (out_ready_in),
      .o_word       (word),
      .o_last       (last),
      .o_flush_done (flush_done),
      .o_err        (err),
      .o_fill       (fill)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready_in = 1'b1; flush = 1'b0;
      code = '0; len = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_fill", 64'(fill), 64'd0);
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_last", 64'(last), 64'd0);
      chk("rst_done", 64'(flush_done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);

      // 1: three 12-bit codes, then flush the 4-bit remainder
      in_valid = 1'b1; code = 36'hD41; len = 6'd12;
      tick(); tick(); tick();
      in_valid = 1'b0;
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_word", 64'(word), 64'hD41D41D4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t1_fill", 64'(fill), 64'd4);
      chk("t1_fvalid", 64'(out_valid), 64'd1);
      chk("t1_fword", 64'(word), 64'h10000000);
      chk("t1_last", 64'(last), 64'd1);
      chk("t1_fready", 64'(ready), 64'd0);
      tick();
      chk("t1_done", 64'(flush_done), 64'd1);
      chk("t1_dvalid", 64'(out_valid), 64'd0);
      tick();
      chk("t1_done_pulse", 64'(flush_done), 64'd0);
      chk("t1_ready_back", 64'(ready), 64'd1);

      // 2: flush of an empty buffer
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t2_valid", 64'(out_valid), 64'd0);
      chk("t2_done_early", 64'(flush_done), 64'd0);
      tick();
      chk("t2_done", 64'(flush_done), 64'd1);
      tick();
      chk("t2_done_pulse", 64'(flush_done), 64'd0);

      // 3: backpressure with 36-bit codes
      out_ready_in = 1'b0;
      in_valid = 1'b1; code = 36'h123456789; len = 6'd36;
      chk("t3_ready0", 64'(ready), 64'd1);
      tick();
      code = 36'hABCDEF012;
      chk("t3_fill36", 64'(fill), 64'd36);
      chk("t3_ready1", 64'(ready), 64'd1);
      tick();
      code = 36'hFFFFFFFFF;
      chk("t3_fill72", 64'(fill), 64'd72);
      chk("t3_stall", 64'(ready), 64'd0);
      tick();
      in_valid = 1'b0;
      chk("t3_fill_hold", 64'(fill), 64'd72);
      chk("t3_word_hold", 64'(word), 64'h12345678);
      out_ready_in = 1'b1;
      chk("t3_valid", 64'(out_valid), 64'd1);
      tick();
      chk("t3_fill40", 64'(fill), 64'd40);
      chk("t3_word2", 64'(word), 64'h9ABCDEF0);
      chk("t3_ready_back", 64'(ready), 64'd1);
      tick();
      chk("t3_fill8", 64'(fill), 64'd8);
      chk("t3_valid_off", 64'(out_valid), 64'd0);
      chk("t3_residue", 64'(word), 64'h12000000);
      do_reset();

      // 4: steady 32-bit stream, one word per cycle
      out_ready_in = 1'b1; in_valid = 1'b1; len = 6'd32;
      for (int i = 1; i <= 8; i++) begin
         code = 36'(i);
         if (i > 1) begin
            chk("t4_valid", 64'(out_valid), 64'd1);
            chk("t4_word", 64'(word), 64'(i - 1));
            chk("t4_fill", 64'(fill), 64'd32);
            chk("t4_ready", 64'(ready), 64'd1);
         end
         tick();
      end
      in_valid = 1'b0;
      chk("t4_last_word", 64'(word), 64'd8);
      tick();
      chk("t4_drained", 64'(fill), 64'd0);
      do_reset();

      // 5: oversize length, zero length, masking
      out_ready_in = 1'b0;
      in_valid = 1'b1; code = 36'hF0000000F; len = 6'd40;
      tick();
      chk("t5_err", 64'(err), 64'd1);
      chk("t5_fill36", 64'(fill), 64'd36);
      chk("t5_word", 64'(word), 64'hF0000000);
      code = 36'hFFFFFFFFF; len = 6'd0;
      tick();
      in_valid = 1'b0;
      chk("t5_len0_fill", 64'(fill), 64'd36);
      out_ready_in = 1'b1;
      tick();
      out_ready_in = 1'b0;
      chk("t5_tail_fill", 64'(fill), 64'd4);
      chk("t5_tail_word", 64'(word), 64'hF0000000);
      chk("t5_err_sticky", 64'(err), 64'd1);
      do_reset();
      chk("t5_err_clr", 64'(err), 64'd0);
      in_valid = 1'b1; code = 36'hFFFFFFFF5; len = 6'd4;
      tick();
      code = 36'h0F0000000; len = 6'd28;
      tick();
      in_valid = 1'b0;
      chk("t5_mask_fill", 64'(fill), 64'd32);
      chk("t5_mask_word", 64'(word), 64'h50000000);
      do_reset();

      // 6: reset while a padded word is pending in FLUSH
      out_ready_in = 1'b0;
      in_valid = 1'b1; code = 36'hABC; len = 6'd12;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t6_fvalid", 64'(out_valid), 64'd1);
      chk("t6_flast", 64'(last), 64'd1);
      chk("t6_fword", 64'(word), 64'hABC00000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_valid", 64'(out_valid), 64'd0);
      chk("t6_fill", 64'(fill), 64'd0);
      chk("t6_ready", 64'(ready), 64'd1);
      chk("t6_no_done0", 64'(flush_done), 64'd0);
      tick();
      chk("t6_no_done1", 64'(flush_done), 64'd0);
      tick();
      chk("t6_no_done2", 64'(flush_done), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
